// File: rtl/vector_unit_pkg.sv
// Shared encodings and default sizing for the vector unit.
package vector_unit_pkg;
  localparam int LANES_DEF = 4;
  localparam int EW_DEF    = 8;
  localparam int AW_DEF    = 8;
  localparam int NVR_DEF   = 4;

  typedef enum logic [1:0] {
    OP_VADD   = 2'b00,
    OP_VSUB   = 2'b01,
    OP_VLOAD  = 2'b10,
    OP_VSTORE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WB    = 3'd2,
    ST_LOAD  = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;
endpackage

// File: rtl/vector_unit_vrf_bank.sv
// Vector register file: two read ports, one debug read port, one write port.
module vrf_bank
  import vector_unit_pkg::*;
#(
  parameter  int NVR = NVR_DEF,
  parameter  int VW  = LANES_DEF * EW_DEF,
  localparam int VRW = $clog2(NVR)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           we,
  input  logic [VRW-1:0] wsel,
  input  logic [VW-1:0]  wdata,
  input  logic [VRW-1:0] ra_sel,
  output logic [VW-1:0]  ra_data,
  input  logic [VRW-1:0] rb_sel,
  output logic [VW-1:0]  rb_data,
  input  logic [VRW-1:0] dbg_sel,
  output logic [VW-1:0]  dbg_data
);
  logic [NVR-1:0][VW-1:0] regs_q, regs_d;

  // Whole-vector write; a register never holds a partially updated value.
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wsel] = wdata;
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clock) begin
    if (!reset) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign ra_data  = regs_q[ra_sel];
  assign rb_data  = regs_q[rb_sel];
  assign dbg_data = regs_q[dbg_sel];
endmodule

// File: rtl/vector_unit.sv
// Vector unit: lane-wise add/sub on the VRF plus element-serial load/store.
// Every command retires through WB before DONE; VSTORE passes WB without a write.
module vector_unit
  import vector_unit_pkg::*;
#(
  parameter  int LANES = LANES_DEF,
  parameter  int EW    = EW_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int NVR   = NVR_DEF,
  localparam int VRW   = $clog2(NVR),
  localparam int VW    = LANES * EW
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [VRW-1:0] vd,
  input  logic [VRW-1:0] vs,
  input  logic [AW-1:0]  base,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [EW-1:0]  mem_wdata,
  input  logic [EW-1:0]  mem_rdata,
  input  logic [VRW-1:0] vreg_sel,
  output logic [VW-1:0]  vreg_view
);
  localparam int CW = $clog2(LANES + 1);

  state_e                   state_q, state_d;
  op_e                      op_q, op_d;
  logic [VRW-1:0]           vd_q, vd_d, vs_q, vs_d;
  logic [AW-1:0]            base_q, base_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  // Packed lane index LANES-1 is the MSB lane, i.e. architectural lane 0.
  logic [LANES-1:0][EW-1:0] x1_q, x1_d, x2_q, x2_d, t_q, t_d, res;
  logic [VW-1:0]            rd_a, rd_b, vrf_wdata;
  logic                     vrf_we;

  vrf_bank #(.NVR(NVR), .VW(VW)) u_vrf (
    .clock    (clock),
    .reset    (reset),
    .we       (vrf_we),
    .wsel     (vd_q),
    .wdata    (vrf_wdata),
    .ra_sel   (vd_q),
    .ra_data  (rd_a),
    .rb_sel   (vs_q),
    .rb_data  (rd_b),
    .dbg_sel  (vreg_sel),
    .dbg_data (vreg_view)
  );

  // Lane-wise modular add/sub; no carry crosses a lane boundary.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign res[g] = (op_q == OP_VSUB) ? x1_q[g] - x2_q[g] : x1_q[g] + x2_q[g];
  end

  assign vrf_we    = (state_q == ST_WB) && (op_q != OP_VSTORE);
  assign vrf_wdata = (op_q == OP_VLOAD) ? t_q : res;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; LOAD runs one extra cycle to catch the last read beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ: begin
        case (op_q)
          OP_VLOAD:  state_d = ST_LOAD;
          OP_VSTORE: state_d = ST_STORE;
          default:   state_d = ST_WB;
        endcase
      end
      ST_LOAD:  if (cnt_q == CW'(LANES))     state_d = ST_WB;
      ST_STORE: if (cnt_q == CW'(LANES - 1)) state_d = ST_WB;
      ST_WB:    state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch, operand capture, lane counter and load buffer.
  always_comb begin
    op_d   = op_q;
    vd_d   = vd_q;
    vs_d   = vs_q;
    base_d = base_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    t_d    = t_q;
    cnt_d  = '0;
    if (state_q == ST_IDLE && start) begin
      op_d   = op_e'(op);
      vd_d   = vd;
      vs_d   = vs;
      base_d = base;
    end
    if (state_q == ST_READ) begin
      x1_d = rd_a;
      x2_d = rd_b;
    end
    if ((state_q == ST_LOAD || state_q == ST_STORE) && state_d == state_q)
      cnt_d = cnt_q + CW'(1);
    // Read data lags the strobe by one cycle, so beat i lands while cnt == i+1.
    if (state_q == ST_LOAD) begin
      for (int j = 0; j < LANES; j++)
        if (cnt_q == CW'(j + 1)) t_d[LANES-1-j] = mem_rdata;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q   <= OP_VADD;
      vd_q   <= '0;
      vs_q   <= '0;
      base_q <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      t_q    <= '0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      vd_q   <= vd_d;
      vs_q   <= vs_d;
      base_q <= base_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      t_q    <= t_d;
      cnt_q  <= cnt_d;
    end
  end

  // Memory-side outputs; held at zero whenever no beat is being issued.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_LOAD && cnt_q < CW'(LANES)) begin
      mem_rd   = 1'b1;
      mem_addr = base_q + AW'(cnt_q);
    end
    if (state_q == ST_STORE) begin
      mem_wr   = 1'b1;
      mem_addr = base_q + AW'(cnt_q);
      for (int j = 0; j < LANES; j++)
        if (cnt_q == CW'(j)) mem_wdata = x1_q[LANES-1-j];
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
endmodule

// File: tb/tb_vector_unit.sv
// Scoreboard bench for vector_unit: stimulus queues expectations, monitor checks.
module tb_vector_unit;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  op = '0, vd = '0, vs = '0, vreg_sel = '0;
  logic [7:0]  base = '0;
  logic        busy, done, mem_rd, mem_wr;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [31:0] vreg_view;
  logic [7:0]  mem [256];

  int cyc = 0, total = 0, bad = 0, done_cnt = 0, acc = 0, nd = 0, a0 = 0;
  bit mon_en = 1'b0;

  typedef struct { bit wr; logic [7:0] addr; logic [7:0] data; int cyc; } bus_t;
  typedef struct { int cyc; logic [31:0] val; } done_t;
  typedef struct { int kind; logic [31:0] exp; } probe_t;
  bus_t   bus_q[$];
  done_t  done_q[$];
  probe_t probe_q[$];
  bus_t   mb;
  done_t  md;
  probe_t mp;

  vector_unit dut (
    .clock(clk), .reset(rst_n), .start(start), .op(op), .vd(vd), .vs(vs),
    .base(base), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vreg_sel(vreg_sel), .vreg_view(vreg_view)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
    mem[8'h20] = 8'hFF; mem[8'h21] = 8'h01; mem[8'h22] = 8'h02; mem[8'h23] = 8'h03;
    mem[8'h30] = 8'hAA; mem[8'h31] = 8'hBB; mem[8'h32] = 8'hCC; mem[8'h33] = 8'hDD;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every negedge, check bus beats, done pulses and queued probes.
  always @(negedge clk) if (mon_en) begin
    chk("strobe_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
    if (mem_rd || mem_wr) begin
      if (bus_q.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_extra: got strobe at addr 0x%0h want none (cycle %0d)", mem_addr, cyc);
      end else begin
        mb = bus_q.pop_front();
        chk("bus_kind", {31'd0, mem_wr}, {31'd0, mb.wr});
        chk("bus_addr", {24'd0, mem_addr}, {24'd0, mb.addr});
        chk("bus_cycle", cyc, mb.cyc);
        if (mb.wr) chk("bus_wdata", {24'd0, mem_wdata}, {24'd0, mb.data});
      end
    end else begin
      chk("idle_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL done_extra: got done pulse want none (cycle %0d)", cyc);
      end else begin
        md = done_q.pop_front();
        chk("done_cycle", cyc, md.cyc);
        chk("done_view", vreg_view, md.val);
      end
    end
    while (probe_q.size() > 0) begin
      mp = probe_q.pop_front();
      case (mp.kind)
        0: chk("busy", {31'd0, busy}, mp.exp);
        1: chk("done", {31'd0, done}, mp.exp);
        2: chk("vreg_view", vreg_view, mp.exp);
        3: chk("done_count", done_cnt, mp.exp);
        4: chk("queues_empty", bus_q.size() + done_q.size(), mp.exp);
        default: chk("mem_out", {14'd0, mem_rd, mem_wr, mem_addr, mem_wdata}, mp.exp);
      endcase
    end
  end

  task automatic probe(input int k, input logic [31:0] e);
    probe_q.push_back('{k, e});
  endtask

  task automatic issue(input logic [1:0] o, input int d, input int s, input logic [7:0] b);
    @(negedge clk);
    op = o; vd = 2'(d); vs = 2'(s); base = b; vreg_sel = 2'(d); start = 1'b1;
    @(posedge clk); #1;
    acc = cyc; start = 1'b0;
  endtask

  task automatic exp_load(input logic [7:0] b, input int at);
    for (int j = 0; j < 4; j++) bus_q.push_back('{1'b0, 8'(b + 8'(j)), 8'h00, at + 1 + j});
  endtask

  task automatic exp_done(input int c, input logic [31:0] v);
    done_q.push_back('{c, v});
    nd++;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (done_cnt >= n) return;
    end
    probe(3, n);
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] sw;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    // Reset state while reset is held low.
    probe(0, 0); probe(1, 0); probe(5, 0);
    for (int s = 0; s < 4; s++) begin
      vreg_sel = 2'(s); probe(2, 32'h0);
      @(negedge clk); #1;
    end
    @(negedge clk); rst_n = 1'b1;

    // VLOAD V1 from 0x10..0x13, latency 8.
    issue(2'b10, 1, 0, 8'h10);
    exp_load(8'h10, acc); exp_done(acc + 7, 32'h01020304);
    wait_done(nd);

    // VLOAD V2 from 0x20..0x23.
    issue(2'b10, 2, 0, 8'h20);
    exp_load(8'h20, acc); exp_done(acc + 7, 32'hFF010203);
    wait_done(nd);

    // VADD V1 += V2, lane 0 wraps, latency 3.
    issue(2'b00, 1, 2, 8'h00);
    exp_done(acc + 2, 32'h00030507);
    wait_done(nd);

    // VSUB V1 -= V1 with vd==vs.
    issue(2'b01, 1, 1, 8'h00);
    exp_done(acc + 2, 32'h00000000);
    wait_done(nd);

    // Mid-command start pulse ignored; start held through DONE accepted in IDLE.
    issue(2'b10, 0, 0, 8'h10);
    a0 = acc;
    exp_load(8'h10, a0);
    exp_done(a0 + 7, 32'h01020304);
    exp_done(a0 + 11, 32'h02040608);
    while (cyc < a0 + 3) @(negedge clk);
    op = 2'b11; vd = 2'd3; base = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    op = 2'b00; vd = 2'd0; vs = 2'd0; start = 1'b1;
    while (cyc < a0 + 9) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done(nd);

    // Reset during the second LOAD cycle aborts without write or done.
    issue(2'b10, 2, 0, 8'h20);
    a0 = acc;
    bus_q.push_back('{1'b0, 8'h20, 8'h00, a0 + 1});
    bus_q.push_back('{1'b0, 8'h21, 8'h00, a0 + 2});
    while (cyc < a0 + 2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    vreg_sel = 2'd0;
    probe(0, 0); probe(1, 0); probe(5, 0); probe(2, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    for (int s = 1; s < 4; s++) begin
      vreg_sel = 2'(s); probe(2, 32'h0);
      @(negedge clk); #1;
    end
    repeat (10) @(negedge clk);
    probe(3, nd);

    // Fresh command after the abort: VLOAD V3 = AABBCCDD.
    issue(2'b10, 3, 0, 8'h30);
    exp_load(8'h30, acc); exp_done(acc + 7, 32'hAABBCCDD);
    wait_done(nd);

    // VSTORE V3 at 0xFE with address wrap, latency 7.
    issue(2'b11, 3, 0, 8'hFE);
    sw = 32'hAABBCCDD;
    for (int j = 0; j < 4; j++)
      bus_q.push_back('{1'b1, 8'(8'hFE + 8'(j)), sw[31-8*j -: 8], acc + 1 + j});
    exp_done(acc + 6, 32'hAABBCCDD);
    wait_done(nd);

    repeat (3) @(negedge clk);
    probe(4, 0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
endmodule
